// File: rtl/dpwm_pkg.sv
// Shared definitions for the DPWM soft-start block: FSM state encoding,
// duty-code limits and the duty-code to percent convention.
package dpwm_pkg;

  // Encoding is visible on the debug LEDs, so it is fixed explicitly.
  typedef enum logic [1:0] {
    S_OFF     = 2'b00,
    S_RAMP_UP = 2'b01,
    S_RUN     = 2'b10,
    S_RAMP_DN = 2'b11
  } state_t;

  localparam int         DUTY_W   = 5;
  localparam logic [4:0] DUTY_MAX = 5'd19;
  localparam int         FS_MAX   = 9;

  // Duty code d occupies (d+1)*5 percent of the switching period.
  function automatic int duty_to_pct(input logic [4:0] code);
    return (int'(code) + 32'sd1) * 32'sd5;
  endfunction

endpackage

// File: rtl/dpwm_softstart_if.sv
// Operator-side control inputs and DPWM-side outputs of the soft-start block.
// The master side drives the operator controls; the slave side is the
// soft-start controller itself.
interface dpwm_softstart_if;
  import dpwm_pkg::*;

  logic       i_start;
  logic       i_fault;
  logic [4:0] i_duty_target;
  logic [4:0] o_duty;
  logic       o_update;
  logic       o_enable;
  logic       o_at_target;
  logic       o_fault_latch;
  logic [1:0] o_state;

  modport master (
    output i_start, i_fault, i_duty_target,
    input  o_duty, o_update, o_enable, o_at_target, o_fault_latch, o_state
  );

  modport slave (
    input  i_start, i_fault, i_duty_target,
    output o_duty, o_update, o_enable, o_at_target, o_fault_latch, o_state
  );

endinterface

// File: rtl/dpwm_step_timer.sv
// Free-running step interval counter: counts 0..STEP_CYCLES-1 and wraps,
// flagging the terminal count with tick. A synchronous clear holds it at 0.
module dpwm_step_timer #(
  parameter int STEP_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int             W    = $clog2(STEP_CYCLES);
  localparam logic [W-1:0]   LAST = W'(STEP_CYCLES - 1);
  localparam logic [W-1:0]   ONE  = W'(1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  // Count step interval cycles, wrapping after the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= {W{1'b0}};
    end else if (tick) begin
      count <= {W{1'b0}};
    end else begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/dpwm_softstart.sv
// Soft-start and duty slew limiter feeding the DPWM generator. Ramps the
// duty code one step per interval toward the operator target, ramps down on
// stop and forces the output off immediately on a fault.
module dpwm_softstart #(
  parameter int         STEP_CYCLES = 50000,
  parameter logic [4:0] DUTY_START  = 5'd0,
  parameter logic [4:0] DUTY_MAX    = dpwm_pkg::DUTY_MAX
) (
  input  logic              CLOCK_50,
  input  logic              i_reset,
  dpwm_softstart_if.slave   bus
);
  import dpwm_pkg::*;

  logic       start_meta, start_sync;
  logic       fault_meta, fault_sync;
  logic [4:0] target_meta, target_sync;
  logic [4:0] tgt;
  logic [4:0] toward;
  logic       tick;
  logic       timer_clr;

  state_t     state, state_next;
  logic [4:0] duty, duty_next;
  logic       enable, enable_next;
  logic       fault_latch, latch_next;
  logic       update, at_target;

  // Two-flop synchronisers for the asynchronous operator inputs.
  always_ff @(posedge CLOCK_50) begin
    if (i_reset) begin
      start_meta  <= 1'b0;
      start_sync  <= 1'b0;
      fault_meta  <= 1'b0;
      fault_sync  <= 1'b0;
      target_meta <= 5'd0;
      target_sync <= 5'd0;
    end else begin
      start_meta  <= bus.i_start;
      start_sync  <= start_meta;
      fault_meta  <= bus.i_fault;
      fault_sync  <= fault_meta;
      target_meta <= bus.i_duty_target;
      target_sync <= target_meta;
    end
  end

  // Clamp the requested target and precompute the one-code move toward it.
  // toward is only used when duty != tgt, so it never wraps.
  assign tgt       = (target_sync > DUTY_MAX) ? DUTY_MAX : target_sync;
  assign toward    = (duty < tgt) ? (duty + 5'd1) : (duty - 5'd1);
  assign timer_clr = (state == S_OFF);

  dpwm_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_timer (
    .clk  (CLOCK_50),
    .rst  (i_reset),
    .clr  (timer_clr),
    .tick (tick)
  );

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (i_reset) begin
      state <= S_OFF;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a synchronised fault overrides every other event.
  always_comb begin
    state_next = state;
    if (fault_sync) begin
      state_next = S_OFF;
    end else begin
      case (state)
        S_OFF: begin
          if (start_sync && !fault_latch) state_next = S_RAMP_UP;
          else                            state_next = S_OFF;
        end
        S_RAMP_UP: begin
          if (!start_sync)      state_next = S_RAMP_DN;
          else if (duty == tgt) state_next = S_RUN;
          else                  state_next = S_RAMP_UP;
        end
        S_RUN: begin
          if (!start_sync) state_next = S_RAMP_DN;
          else             state_next = S_RUN;
        end
        S_RAMP_DN: begin
          if (start_sync)                       state_next = S_RAMP_UP;
          else if (tick && duty == DUTY_START)  state_next = S_OFF;
          else                                  state_next = S_RAMP_DN;
        end
        default: state_next = S_OFF;
      endcase
    end
  end

  // Next values of duty, enable and the sticky fault flag.
  always_comb begin
    duty_next   = duty;
    enable_next = enable;
    latch_next  = fault_latch;
    if (fault_sync) begin
      duty_next   = DUTY_START;
      enable_next = 1'b0;
      latch_next  = 1'b1;
    end else begin
      case (state)
        S_OFF: begin
          duty_next   = DUTY_START;
          enable_next = (state_next == S_RAMP_UP);
          // The flag clears only once the operator has released start.
          if (start_sync) latch_next = fault_latch;
          else            latch_next = 1'b0;
        end
        S_RAMP_UP, S_RUN: begin
          enable_next = 1'b1;
          if (start_sync && tick && duty != tgt) duty_next = toward;
          else                                   duty_next = duty;
        end
        S_RAMP_DN: begin
          if (start_sync) begin
            duty_next   = duty;
            enable_next = 1'b1;
          end else if (tick) begin
            if (duty > DUTY_START) begin
              duty_next   = duty - 5'd1;
              enable_next = 1'b1;
            end else begin
              duty_next   = duty;
              enable_next = 1'b0;
            end
          end else begin
            duty_next   = duty;
            enable_next = 1'b1;
          end
        end
        default: begin
          duty_next   = DUTY_START;
          enable_next = 1'b0;
        end
      endcase
    end
  end

  // Output registers; update flags any change of the applied duty code.
  always_ff @(posedge CLOCK_50) begin
    if (i_reset) begin
      duty        <= DUTY_START;
      enable      <= 1'b0;
      fault_latch <= 1'b0;
      update      <= 1'b0;
      at_target   <= 1'b0;
    end else begin
      duty        <= duty_next;
      enable      <= enable_next;
      fault_latch <= latch_next;
      update      <= (duty_next != duty);
      at_target   <= (state_next == S_RUN) && (duty_next == tgt);
    end
  end

  assign bus.o_duty        = duty;
  assign bus.o_update      = update;
  assign bus.o_enable      = enable;
  assign bus.o_at_target   = at_target;
  assign bus.o_fault_latch = fault_latch;
  assign bus.o_state       = state;

endmodule
